// File: rtl/ecc_secded_apb_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_apb_engine_if
// Brief    : APB3 (no PREADY) bus bundle for the SECDED engine.
// Revision : 1.0
// ============================================================================
interface ecc_secded_apb_engine_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PENABLE;
    logic                       PSEL;
    logic                       PWRITE;

    modport master (
        output PADDR, PWDATA, PENABLE, PSEL, PWRITE,
        input  PRDATA
    );

    modport slave (
        input  PADDR, PWDATA, PENABLE, PSEL, PWRITE,
        output PRDATA
    );
endinterface
`default_nettype wire

// File: rtl/ecc_secded_apb_engine.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_apb_engine
// Brief    : APB-programmable SECDED encoder/decoder, 8/16/32-bit codewords.
// Revision : 1.0
// ============================================================================
module ecc_secded_apb_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ecc_secded_apb_engine_if.slave     apb,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);

    localparam logic [1:0] c_MAX_CW = (DATA_WIDTH >= 32) ? 2'd2 :
                                      (DATA_WIDTH >= 16) ? 2'd1 : 2'd0;

    function automatic int cw_n(input logic [1:0] w);
        case (w)
            2'd0:    return 8;
            2'd1:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cw_k(input logic [1:0] w);
        case (w)
            2'd0:    return 4;
            2'd1:    return 11;
            default: return 26;
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

    function automatic logic [1:0] clamp_cw(input logic [1:0] v);
        if (v == 2'd3 || (32'd8 << v) > 32'(DATA_WIDTH))
            return c_MAX_CW;
        return v;
    endfunction

    // Data bit j sits at the j-th non-power-of-two position >= 3; its position
    // value contributes to every parity bit whose index is set in it.
    function automatic logic [4:0] calc_parity(input logic [31:0] d, input int k);
        logic [4:0] p;
        int         j;
        p = '0;
        j = 0;
        for (int pos = 3; pos < 32; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (j < k && d[j[4:0]])
                    p = p ^ pos[4:0];
                j = j + 1;
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] cw;
        logic [4:0]  p;
        int          n;
        int          k;
        n  = cw_n(w);
        k  = cw_k(w);
        cw = d & low_mask(k);
        p  = calc_parity(cw, k);
        for (int i = 0; i < 5; i++) begin
            if (i < n - k - 1)
                cw[5'(k + i)] = p[i];
        end
        cw[5'(n - 1)] = ^cw;
        return cw;
    endfunction

    // Returns {num_of_errors, corrected data}.
    function automatic logic [33:0] decode(input logic [31:0] cw_raw, input logic [1:0] w);
        logic [31:0] cw;
        logic [31:0] data;
        logic [4:0]  sp;
        logic [4:0]  s;
        logic [1:0]  errs;
        int          n;
        int          k;
        int          j;
        n    = cw_n(w);
        k    = cw_k(w);
        cw   = cw_raw & low_mask(n);
        data = cw & low_mask(k);
        sp   = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < n - k - 1)
                sp[i] = cw[5'(k + i)];
        end
        s    = calc_parity(data, k) ^ sp;
        errs = 2'd0;
        if (^cw) begin
            errs = 2'd1;
            j    = 0;
            for (int pos = 3; pos < 32; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    if (j < k && pos[4:0] == s)
                        data[j[4:0]] = ~data[j[4:0]];
                    j = j + 1;
                end
            end
        end else if (s != 5'd0) begin
            errs = 2'd2;
        end
        return {errs, data};
    endfunction

    logic [1:0]               ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]    data_in_q, data_in_d;
    logic [1:0]               cw_sel_q, cw_sel_d;
    logic [DATA_WIDTH-1:0]    noise_q, noise_d;
    logic                     overrun_q, overrun_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]    s1_cw_q, s1_cw_d;
    logic [1:0]               s1_op_q, s1_op_d;
    logic [1:0]               s1_w_q, s1_w_d;
    logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
    logic [1:0]               num_of_errors_q, num_of_errors_d;
    logic                     operation_done_q, operation_done_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_corr_q, cnt_corr_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_unc_q, cnt_unc_d;

    logic        w_busy;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_op;
    logic [2:0]  w_addr;
    logic        w_start;
    logic [31:0] w_enc;
    logic [31:0] w_s1_word;
    logic [33:0] w_dec;
    logic [AMBA_WORD-1:0] w_prdata;

    assign w_busy  = s1_valid_q | operation_done_q;
    assign w_wr    = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_rd    = apb.PSEL & ~apb.PWRITE;
    assign w_op    = apb.PWDATA[1:0];
    assign w_addr  = apb.PADDR[4:2];
    assign w_start = w_wr && (w_addr == 3'd0) && !w_busy && (w_op != 2'd3);

    assign w_enc = encode(32'(data_in_q), cw_sel_q);
    assign w_dec = decode(32'(s1_cw_q), s1_w_q);

    always_comb begin
        case (w_op)
            2'd0:    w_s1_word = w_enc;
            2'd2:    w_s1_word = w_enc ^ 32'(noise_q);
            default: w_s1_word = 32'(data_in_q);
        endcase
    end

    always_comb begin
        ctrl_d           = ctrl_q;
        data_in_d        = data_in_q;
        cw_sel_d         = cw_sel_q;
        noise_d          = noise_q;
        overrun_d        = overrun_q;
        s1_valid_d       = 1'b0;
        s1_cw_d          = s1_cw_q;
        s1_op_d          = s1_op_q;
        s1_w_d           = s1_w_q;
        data_out_d       = data_out_q;
        num_of_errors_d  = num_of_errors_q;
        operation_done_d = 1'b0;
        cnt_corr_d       = cnt_corr_q;
        cnt_unc_d        = cnt_unc_q;

        if (w_start) begin
            s1_valid_d = 1'b1;
            s1_op_d    = w_op;
            s1_w_d     = cw_sel_q;
            s1_cw_d    = DATA_WIDTH'(w_s1_word);
        end

        if (s1_valid_q) begin
            operation_done_d = 1'b1;
            if (s1_op_q == 2'd0) begin
                data_out_d      = s1_cw_q;
                num_of_errors_d = 2'd0;
            end else begin
                data_out_d      = DATA_WIDTH'(w_dec[31:0]);
                num_of_errors_d = w_dec[33:32];
                if (w_dec[33:32] == 2'd1 && cnt_corr_q != '1)
                    cnt_corr_d = cnt_corr_q + 1'b1;
                if (w_dec[33:32] == 2'd2 && cnt_unc_q != '1)
                    cnt_unc_d = cnt_unc_q + 1'b1;
            end
        end

        // Register writes come last so an ERR_CNT clear overrides a same-cycle increment.
        if (w_wr) begin
            case (w_addr)
                3'd0: begin
                    if (!w_busy)
                        ctrl_d = w_op;
                    else if (w_op != 2'd3)
                        overrun_d = 1'b1;
                end
                3'd1: data_in_d = apb.PWDATA[DATA_WIDTH-1:0];
                3'd2: cw_sel_d  = clamp_cw(apb.PWDATA[1:0]);
                3'd3: noise_d   = apb.PWDATA[DATA_WIDTH-1:0];
                3'd5: begin
                    cnt_corr_d = '0;
                    cnt_unc_d  = '0;
                    overrun_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_prdata = '0;
        if (w_rd) begin
            case (w_addr)
                3'd0:    w_prdata = AMBA_WORD'(ctrl_q);
                3'd1:    w_prdata = AMBA_WORD'(data_in_q);
                3'd2:    w_prdata = AMBA_WORD'(cw_sel_q);
                3'd3:    w_prdata = AMBA_WORD'(noise_q);
                3'd4:    w_prdata = AMBA_WORD'({num_of_errors_q, overrun_q, w_busy});
                3'd5:    w_prdata = AMBA_WORD'({16'(cnt_unc_q), 16'(cnt_corr_q)});
                default: w_prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA = w_prdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q           <= '0;
            data_in_q        <= '0;
            cw_sel_q         <= '0;
            noise_q          <= '0;
            overrun_q        <= 1'b0;
            s1_valid_q       <= 1'b0;
            s1_cw_q          <= '0;
            s1_op_q          <= '0;
            s1_w_q           <= '0;
            data_out_q       <= '0;
            num_of_errors_q  <= '0;
            operation_done_q <= 1'b0;
            cnt_corr_q       <= '0;
            cnt_unc_q        <= '0;
        end else begin
            ctrl_q           <= ctrl_d;
            data_in_q        <= data_in_d;
            cw_sel_q         <= cw_sel_d;
            noise_q          <= noise_d;
            overrun_q        <= overrun_d;
            s1_valid_q       <= s1_valid_d;
            s1_cw_q          <= s1_cw_d;
            s1_op_q          <= s1_op_d;
            s1_w_q           <= s1_w_d;
            data_out_q       <= data_out_d;
            num_of_errors_q  <= num_of_errors_d;
            operation_done_q <= operation_done_d;
            cnt_corr_q       <= cnt_corr_d;
            cnt_unc_q        <= cnt_unc_d;
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = num_of_errors_q;
    assign operation_done = operation_done_q;

    logic unused_bits;
    assign unused_bits = ^{apb.PADDR, apb.PWDATA, w_enc, w_dec};

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_apb_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_secded_apb_engine
// Brief    : Scoreboard bench for the SECDED APB engine (ERR_CNT_WIDTH = 2).
// Revision : 1.0
// ============================================================================
module tb_ecc_secded_apb_engine;

    localparam int c_DW = 32;
    localparam int c_AW = 20;
    localparam int c_WW = 32;
    localparam int c_CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecc_secded_apb_engine_if #(.AMBA_ADDR_WIDTH(c_AW), .AMBA_WORD(c_WW)) bus ();

    logic [c_DW-1:0] data_out;
    logic            operation_done;
    logic [1:0]      num_of_errors;

    ecc_secded_apb_engine #(
        .DATA_WIDTH(c_DW), .AMBA_ADDR_WIDTH(c_AW), .AMBA_WORD(c_WW), .ERR_CNT_WIDTH(c_CW)
    ) dut (
        .clk(clk), .rst(rst), .apb(bus),
        .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] sb_q[$];
    bit          prev_done = 1'b0;

    logic [31:0] sh_data, sh_noise;
    int          sh_n;
    int          m_corr, m_unc;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: syndrome as the XOR of the Hamming positions of all set bits.
    function automatic int kof(input int n);
        return (n == 8) ? 4 : (n == 16) ? 11 : 26;
    endfunction

    function automatic int dpos(input int j);
        int c = 0;
        for (int p = 3; p < 64; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (c == j) return p;
                c++;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] d, input int n);
        logic [31:0] cw = '0;
        int k = kof(n);
        int syn = 0;
        for (int j = 0; j < k; j++)
            if (d[j]) begin cw[j] = 1'b1; syn ^= dpos(j); end
        for (int i = 0; i < n - k - 1; i++) cw[k + i] = syn[i];
        cw[n - 1] = ^cw;
        return cw;
    endfunction

    task automatic m_dec(input logic [31:0] cw_in, input int n, output logic [31:0] data, output logic [1:0] errs);
        logic [31:0] cw;
        int k = kof(n);
        int syn = 0;
        cw   = (n == 32) ? cw_in : (cw_in & ((32'd1 << n) - 1));
        data = '0;
        for (int j = 0; j < k; j++)
            if (cw[j]) begin data[j] = 1'b1; syn ^= dpos(j); end
        for (int i = 0; i < n - k - 1; i++)
            if (cw[k + i]) syn ^= (1 << i);
        if (^cw) begin
            errs = 2'd1;
            for (int j = 0; j < k; j++)
                if (dpos(j) == syn) data[j] = ~data[j];
        end else begin
            errs = (syn != 0) ? 2'd2 : 2'd0;
        end
    endtask

    always @(negedge clk) begin
        if (operation_done) begin
            chk_eq("done_one_cycle", 64'(prev_done), 64'd0);
            chk_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                logic [33:0] e;
                e = sb_q.pop_front();
                chk_eq("sb_data_out", 64'(data_out), 64'(e[31:0]));
                chk_eq("sb_num_err", 64'(num_of_errors), 64'(e[33:32]));
            end
        end
        prev_done = operation_done;
    end

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = c_AW'(a); bus.PWDATA = d;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b1; bus.PADDR = c_AW'(a);
        #2 d = bus.PRDATA;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (operation_done) begin seen = 1'b1; lat = i; end
        end
    endtask

    task automatic push_expected(input logic [1:0] op);
        logic [31:0] dd;
        logic [1:0]  ee;
        case (op)
            2'd0:    begin dd = m_enc(sh_data, sh_n); ee = 2'd0; end
            2'd1:    m_dec(sh_data, sh_n, dd, ee);
            default: m_dec(m_enc(sh_data, sh_n) ^ sh_noise, sh_n, dd, ee);
        endcase
        if (ee == 2'd1 && m_corr < 3) m_corr++;
        if (ee == 2'd2 && m_unc < 3) m_unc++;
        sb_q.push_back({ee, dd});
    endtask

    task automatic run_op(input logic [1:0] op);
        int lat;
        push_expected(op);
        apb_write(5'h00, 32'(op));
        wait_done(lat);
        chk_eq("op_latency", 64'(lat), 64'd2);
    endtask

    task automatic set_width(input logic [1:0] w);
        apb_write(5'h08, 32'(w));
        sh_n = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endtask

    task automatic set_data(input logic [31:0] d);
        apb_write(5'h04, d);
        sh_data = d;
    endtask

    task automatic set_noise(input logic [31:0] d);
        apb_write(5'h0C, d);
        sh_noise = d;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          lat;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        sh_data = '0; sh_noise = '0; sh_n = 8; m_corr = 0; m_unc = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk_eq("rst_data_out", 64'(data_out), 64'd0);
        chk_eq("rst_num_err", 64'(num_of_errors), 64'd0);
        chk_eq("rst_done", 64'(operation_done), 64'd0);
        apb_read(5'h10, r); chk_eq("rst_status", 64'(r), 64'd0);
        apb_read(5'h14, r); chk_eq("rst_err_cnt", 64'(r), 64'd0);

        // Directed 8-bit cases with hand-computed results.
        set_width(2'd0);
        set_data(32'hA);
        run_op(2'd0);
        chk_eq("enc8_data", 64'(data_out), 64'hAA);
        chk_eq("enc8_err", 64'(num_of_errors), 64'd0);

        set_data(32'hA8);
        run_op(2'd1);
        chk_eq("dec8_data", 64'(data_out), 64'hA);
        chk_eq("dec8_err", 64'(num_of_errors), 64'd1);
        apb_read(5'h14, r); chk_eq("dec8_cnt", 64'(r), 64'h1);

        set_data(32'hA);
        set_noise(32'h3);
        run_op(2'd2);
        chk_eq("full8_data", 64'(data_out), 64'h9);
        chk_eq("full8_err", 64'(num_of_errors), 64'd2);
        apb_read(5'h14, r); chk_eq("full8_cnt", 64'(r), 64'h0001_0001);
        apb_read(5'h10, r); chk_eq("full8_status", 64'(r), 64'h8);
        apb_read(5'h00, r); chk_eq("ctrl_readback", 64'(r), 64'h2);

        apb_write(5'h08, 32'h3);
        apb_read(5'h08, r); chk_eq("cw_clamp", 64'(r), 64'h2);
        apb_read(5'h18, r); chk_eq("unmapped_read", 64'(r), 64'h0);

        // Randomised operations over all widths with 0..2 flipped bits.
        apb_write(5'h14, 32'h0);
        m_corr = 0; m_unc = 0;
        for (int it = 0; it < 24; it++) begin
            logic [1:0]  op;
            logic [31:0] nz;
            logic [31:0] d;
            int          nf;
            set_width(2'(it % 3));
            op = 2'($urandom_range(0, 2));
            nz = '0;
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) nz[$urandom_range(0, sh_n - 1)] = 1'b1;
            d = $urandom;
            if (op == 2'd1) set_data(m_enc(d, sh_n) ^ nz);
            else begin set_data(d); set_noise(nz); end
            run_op(op);
        end
        apb_read(5'h14, r);
        chk_eq("rand_cnt", 64'(r), 64'({16'(m_unc), 16'(m_corr)}));

        // Overrun: second CTRL write lands one cycle after the accepted one.
        apb_write(5'h14, 32'h0);
        set_width(2'd0);
        set_data(32'hA);
        push_expected(2'd0);
        apb_write(5'h00, 32'h0);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
        bus.PADDR = '0; bus.PWDATA = 32'h1;
        @(posedge clk); #1;
        apb_read(5'h10, r); chk_eq("overrun_status_busy", 64'(r), 64'h3);
        repeat (4) @(posedge clk); #1;
        apb_read(5'h10, r); chk_eq("overrun_sticky", 64'(r), 64'h2);
        apb_write(5'h14, 32'hDEAD);
        apb_read(5'h10, r); chk_eq("overrun_cleared", 64'(r), 64'h0);

        // Snapshot: DATA_IN rewritten while the encode is in flight.
        set_data(32'h5);
        push_expected(2'd0);
        apb_write(5'h00, 32'h0);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
        bus.PADDR = c_AW'(5'h04); bus.PWDATA = 32'hF;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        wait_done(lat);
        chk_eq("snap_done_seen", 64'(lat > 0), 64'd1);
        chk_eq("snap_data", 64'(data_out), 64'h55);
        apb_read(5'h04, r); chk_eq("snap_new_data_in", 64'(r), 64'hF);

        // Counter saturation at 2^2-1.
        apb_write(5'h14, 32'h0);
        set_data(32'hA8);
        for (int i = 0; i < 5; i++) run_op(2'd1);
        apb_read(5'h14, r); chk_eq("sat_cnt", 64'(r), 64'h3);

        // Reset during an operation: no pulse, everything back to zero.
        set_data(32'hA);
        apb_write(5'h00, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk_eq("rst_mid_data_out", 64'(data_out), 64'd0);
        chk_eq("rst_mid_num_err", 64'(num_of_errors), 64'd0);
        apb_read(5'h10, r); chk_eq("rst_mid_status", 64'(r), 64'd0);
        apb_read(5'h14, r); chk_eq("rst_mid_cnt", 64'(r), 64'd0);
        apb_read(5'h04, r); chk_eq("rst_mid_data_in", 64'(r), 64'd0);

        chk_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
